// File: rtl/rf_writeback_merge_pkg.sv
// rf_wb_pkg: shared types and helpers for the register-file writeback merge.
//   aw_of()        - register address width for a given EMBEDDED setting
//   wb_req_t       - one register write request {rd, data}
//   wb_fifo_ent_t  - load FIFO entry: request plus a sticky kill flag
// rd is always carried at the RV32I width (5 bits). RV32E builds
// zero-extend their 4-bit addresses into it.
package rf_wb_pkg;

  localparam int RD_W = 5;

  function automatic int aw_of(input int embedded);
    return (embedded != 0) ? 4 : 5;
  endfunction

  typedef struct packed {
    logic [RD_W-1:0] rd;
    logic [31:0]     data;
  } wb_req_t;

  typedef struct packed {
    wb_req_t req;
    logic    kill;
  } wb_fifo_ent_t;

endpackage

// File: rtl/rf_writeback_merge_if.sv
// rf_writeback_merge_if: bundle of the writeback stage signals.
//   ALU lanes   : alu{0,1}_valid/_rd/_data          (master -> slave)
//   Load return : ld_valid/_rd/_data -> ld_ready    (valid/ready)
//   Issue       : iss_ld_valid/_rd -> busy          (pending-load scoreboard)
//   RF ports    : rf{0,1}_rd_addr/_data             (slave -> master, addr 0 = idle)
// AW must match the AW derived from EMBEDDED in the module using this interface.
interface rf_writeback_merge_if #(parameter int AW = 4) ();

  localparam int NR = 1 << AW;

  logic          alu0_valid;
  logic [AW-1:0] alu0_rd;
  logic [31:0]   alu0_data;
  logic          alu1_valid;
  logic [AW-1:0] alu1_rd;
  logic [31:0]   alu1_data;
  logic          ld_valid;
  logic [AW-1:0] ld_rd;
  logic [31:0]   ld_data;
  logic          ld_ready;
  logic          iss_ld_valid;
  logic [AW-1:0] iss_ld_rd;
  logic [NR-1:0] busy;
  logic [AW-1:0] rf0_rd_addr;
  logic [31:0]   rf0_rd_data;
  logic [AW-1:0] rf1_rd_addr;
  logic [31:0]   rf1_rd_data;

  modport master (
    output alu0_valid, alu0_rd, alu0_data,
    output alu1_valid, alu1_rd, alu1_data,
    output ld_valid, ld_rd, ld_data,
    output iss_ld_valid, iss_ld_rd,
    input  ld_ready, busy,
    input  rf0_rd_addr, rf0_rd_data, rf1_rd_addr, rf1_rd_data
  );

  modport slave (
    input  alu0_valid, alu0_rd, alu0_data,
    input  alu1_valid, alu1_rd, alu1_data,
    input  ld_valid, ld_rd, ld_data,
    input  iss_ld_valid, iss_ld_rd,
    output ld_ready, busy,
    output rf0_rd_addr, rf0_rd_data, rf1_rd_addr, rf1_rd_data
  );

endinterface

// File: rtl/rf_writeback_merge_fifo.sv
// wb_load_fifo: small load-return buffer with per-entry kill marking.
//   push_i/push_req_i  enqueue (ignored when full)
//   pop_i              drop the head (ignored when empty)
//   kill{0,1}_en_i/_rd_i  mark every live entry whose rd matches
//   head_o/head_valid_o   oldest entry
//   ready_o            registered "not full" after this cycle's push/pop
//   kill{0,1}_hit_o    some live, not-yet-killed entry matched this cycle
// Pointers carry one extra bit so full and empty are distinguishable.
module wb_load_fifo import rf_wb_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push_i,
  input  wb_req_t         push_req_i,
  input  logic            pop_i,
  input  logic            kill0_en_i,
  input  logic [RD_W-1:0] kill0_rd_i,
  input  logic            kill1_en_i,
  input  logic [RD_W-1:0] kill1_rd_i,
  output wb_fifo_ent_t    head_o,
  output logic            head_valid_o,
  output logic            ready_o,
  output logic            kill0_hit_o,
  output logic            kill1_hit_o
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  wb_fifo_ent_t    mem_q [DEPTH];
  logic [PW-1:0]   wrPtr_q, rdPtr_q;
  logic            ready_q;
  logic [PW-1:0]   count, wrNext, rdNext;
  logic            empty, full, fullNext, doPush, doPop;
  logic [DEPTH-1:0] live, match0, match1;

  assign count    = wrPtr_q - rdPtr_q;
  assign empty    = (wrPtr_q == rdPtr_q);
  assign full     = (wrPtr_q[IW] != rdPtr_q[IW]) && (wrPtr_q[IW-1:0] == rdPtr_q[IW-1:0]);
  assign doPush   = push_i && !full;
  assign doPop    = pop_i && !empty;
  assign wrNext   = wrPtr_q + PW'(doPush);
  assign rdNext   = rdPtr_q + PW'(doPop);
  assign fullNext = (wrNext[IW] != rdNext[IW]) && (wrNext[IW-1:0] == rdNext[IW-1:0]);

  // An entry is live when its distance from the head is below the occupancy.
  // Already-killed entries do not report a hit, so each load is killed once.
  always_comb begin
    live   = '0;
    match0 = '0;
    match1 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      live[i]   = ({1'b0, IW'(IW'(i) - rdPtr_q[IW-1:0])} < count);
      match0[i] = live[i] && !mem_q[i].kill && kill0_en_i && (mem_q[i].req.rd == kill0_rd_i);
      match1[i] = live[i] && !mem_q[i].kill && kill1_en_i && (mem_q[i].req.rd == kill1_rd_i);
    end
  end

  // Storage, pointers and the registered ready flag. The push slot is never
  // live, so the push write cannot collide with a kill mark.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      ready_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (match0[i] || match1[i]) mem_q[i].kill <= 1'b1;
      end
      if (doPush) mem_q[wrPtr_q[IW-1:0]] <= '{req: push_req_i, kill: 1'b0};
      wrPtr_q <= wrNext;
      rdPtr_q <= rdNext;
      ready_q <= !fullNext;
    end
  end

  assign head_o       = mem_q[rdPtr_q[IW-1:0]];
  assign head_valid_o = !empty;
  assign ready_o      = ready_q;
  assign kill0_hit_o  = |match0;
  assign kill1_hit_o  = |match1;

endmodule

// File: rtl/rf_writeback_merge.sv
// rf_writeback_merge: writeback stage feeding both register-file write ports.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus (slave): two ALU lanes, load return (valid/ready), issue-side
//                load dispatch, busy scoreboard, two RF write ports
// Lane0 owns port0 and lane1 owns port1; a buffered load borrows whichever
// port its lane leaves idle (port0 first). ALU writes kill older loads to
// the same register.
// Optional build macro RF_WB_LD_BYPASS_EN: a load arriving to an empty FIFO
// with a free port is written straight through instead of being buffered.
module rf_writeback_merge import rf_wb_pkg::*; #(
  parameter int EMBEDDED = 1,
  parameter int LD_DEPTH = 2
) (
  input logic clk,
  input logic rst_n,
  rf_writeback_merge_if.slave bus
);

  localparam int AW = aw_of(EMBEDDED);
  localparam int NR = 1 << AW;

  logic [RD_W-1:0] alu0Rd, alu1Rd, ldRd, issRd;
  logic            alu0Eff, alu1Eff, lane0Write;
  wb_fifo_ent_t    head;
  logic            headValid, headKilled, fifoCand, ldReady, ldAccept, arrKill;
  logic            bypassCand, loadCand, grant0, grant1, pop, push;
  logic            kill0Hit, kill1Hit;
  wb_req_t         loadReq;

  logic [AW-1:0]   rf0Addr_q, rf0Addr_d, rf1Addr_q, rf1Addr_d;
  logic [31:0]     rf0Data_q, rf0Data_d, rf1Data_q, rf1Data_d;
  logic [NR-1:0]   busy_q, busy_d, setMask, clrMask;

  assign alu0Rd = RD_W'(bus.alu0_rd);
  assign alu1Rd = RD_W'(bus.alu1_rd);
  assign ldRd   = RD_W'(bus.ld_rd);
  assign issRd  = RD_W'(bus.iss_ld_rd);

  assign alu0Eff    = bus.alu0_valid && (bus.alu0_rd != '0);
  assign alu1Eff    = bus.alu1_valid && (bus.alu1_rd != '0);
  assign lane0Write = alu0Eff && !(alu1Eff && (alu0Rd == alu1Rd));

  // A head that matches this cycle's ALU write is killed now rather than
  // granted, otherwise both ports could write the same register.
  assign headKilled = headValid && (head.kill ||
                      (alu0Eff && head.req.rd == alu0Rd) ||
                      (alu1Eff && head.req.rd == alu1Rd));
  assign fifoCand   = headValid && !headKilled;

  assign ldAccept = bus.ld_valid && ldReady;
  assign arrKill  = (bus.ld_rd == '0) || (alu0Eff && ldRd == alu0Rd) || (alu1Eff && ldRd == alu1Rd);

`ifdef RF_WB_LD_BYPASS_EN
  assign bypassCand = ldAccept && !arrKill && !headValid && (!alu0Eff || !alu1Eff);
`else
  assign bypassCand = 1'b0;
`endif

  assign loadCand = fifoCand || bypassCand;
  assign loadReq  = fifoCand ? head.req : '{rd: ldRd, data: bus.ld_data};
  assign grant0   = loadCand && !alu0Eff;
  assign grant1   = loadCand && alu0Eff && !alu1Eff;
  assign pop      = headKilled || (fifoCand && (grant0 || grant1));
  assign push     = ldAccept && !arrKill && !bypassCand;

  wb_load_fifo #(.DEPTH(LD_DEPTH)) uFifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_req_i  ('{rd: ldRd, data: bus.ld_data}),
    .pop_i       (pop),
    .kill0_en_i  (alu0Eff),
    .kill0_rd_i  (alu0Rd),
    .kill1_en_i  (alu1Eff),
    .kill1_rd_i  (alu1Rd),
    .head_o      (head),
    .head_valid_o(headValid),
    .ready_o     (ldReady),
    .kill0_hit_o (kill0Hit),
    .kill1_hit_o (kill1Hit)
  );

  // Port selection and scoreboard update. A pending load clears its busy bit
  // when written or when killed (buffered or arriving); a same-cycle issue
  // of the same register re-sets it.
  always_comb begin
    rf0Addr_d = '0;
    rf0Data_d = '0;
    rf1Addr_d = '0;
    rf1Data_d = '0;
    setMask   = '0;
    clrMask   = '0;
    if (lane0Write) begin
      rf0Addr_d = bus.alu0_rd;
      rf0Data_d = bus.alu0_data;
    end else if (grant0) begin
      rf0Addr_d = loadReq.rd[AW-1:0];
      rf0Data_d = loadReq.data;
    end
    if (alu1Eff) begin
      rf1Addr_d = bus.alu1_rd;
      rf1Data_d = bus.alu1_data;
    end else if (grant1) begin
      rf1Addr_d = loadReq.rd[AW-1:0];
      rf1Data_d = loadReq.data;
    end
    if (grant0 || grant1)    clrMask = clrMask | (NR'(1) << loadReq.rd);
    if (kill0Hit)            clrMask = clrMask | (NR'(1) << alu0Rd);
    if (kill1Hit)            clrMask = clrMask | (NR'(1) << alu1Rd);
    if (ldAccept && arrKill) clrMask = clrMask | (NR'(1) << ldRd);
    if (bus.iss_ld_valid)    setMask = NR'(1) << issRd;
    busy_d = ((busy_q & ~clrMask) | setMask) & ~NR'(1);
  end

  // Write-port and scoreboard registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf0Addr_q <= '0;
      rf0Data_q <= '0;
      rf1Addr_q <= '0;
      rf1Data_q <= '0;
      busy_q    <= '0;
    end else begin
      rf0Addr_q <= rf0Addr_d;
      rf0Data_q <= rf0Data_d;
      rf1Addr_q <= rf1Addr_d;
      rf1Data_q <= rf1Data_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.ld_ready    = ldReady;
  assign bus.busy        = busy_q;
  assign bus.rf0_rd_addr = rf0Addr_q;
  assign bus.rf0_rd_data = rf0Data_q;
  assign bus.rf1_rd_addr = rf1Addr_q;
  assign bus.rf1_rd_data = rf1Data_q;

endmodule

// File: doc/rf_writeback_merge.md
Name: rf_writeback_merge

Overview:
- Writeback stage directly upstream of the dual-lane quad-read register file; drives both lanes' write ports (RdAddr/RdData pairs).
- Merges two always-accepted ALU result lanes (lane0 older, lane1 younger) with a back-pressured load-return channel.
- Buffers loads in a small FIFO until a write port is free.
- Keeps a pending-load scoreboard that the issue stage uses to stall.

Parameters:
- EMBEDDED, 1, 1 = RV32E (16 regs, 4-bit addr); 0 = RV32I (32 regs, 5-bit addr). AW = EMBEDDED ? 4 : 5; NR = 1<<AW.
- LD_DEPTH, 2, load FIFO depth; power of 2, >= 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- alu0_valid  in  1  lane0 result valid
- alu0_rd  in  AW  lane0 destination
- alu0_data  in  32  lane0 result
- alu1_valid  in  1  lane1 result valid
- alu1_rd  in  AW  lane1 destination
- alu1_data  in  32  lane1 result
- ld_valid  in  1  load return valid
- ld_rd  in  AW  load destination
- ld_data  in  32  load data
- ld_ready  out  1  FIFO not full
- iss_ld_valid  in  1  issue stage dispatched a load
- iss_ld_rd  in  AW  its destination
- busy  out  NR  per-register pending-load bits
- rf0_rd_addr  out  AW  write port 0 address; 0 = no write
- rf0_rd_data  out  32  write port 0 data
- rf1_rd_addr  out  AW  write port 1 address; 0 = no write
- rf1_rd_data  out  32  write port 1 data

Behaviour:
- Reset: rf*_rd_addr = 0, rf*_rd_data = 0, FIFO empty, busy = 0. ld_ready = 1 one cycle after rst_n deasserts. Reset mid-operation discards all FIFO contents with no write.
- Effective ALU write: valid && rd != 0. If both lanes write the same rd in one cycle, lane1 wins and lane0 is dropped.
- ALU results are never stalled. Inputs sampled in cycle N appear on the port registers in cycle N+1. Lane0 uses port0; lane1 uses port1.
- Load handshake: transfer when ld_valid && ld_ready. ld_ready = !full, registered.
  - Same-cycle dequeue does not free space for enqueue when full.
  - A load with rd == 0 is accepted and discarded.
- Load candidate is the FIFO head, popped only when granted. Grant goes to port0 if lane0 has no effective write, else port1 if lane1 has no effective write, else wait. At most one load write per cycle.
- Enqueue at the end of cycle N, earliest port visibility N+2.
- Kill rule: an effective ALU write to rd X kills every FIFO entry with rd X, plus a same-cycle arriving load to X. ALU writes are always younger than pending loads.
  - Killed entries pop without writing, one per cycle when at head.
  - A killed head does not consume a port.
- Scoreboard:
  - busy[iss_ld_rd] is set on iss_ld_valid.
  - busy[rd] clears when that load is written or killed.
  - Set and clear of the same rd in one cycle: set wins.
  - busy[0] is always 0.
- FIFO pointers wrap modulo LD_DEPTH. Full/empty are tracked with an extra pointer bit.

Optional Feature:
- RF_WB_LD_BYPASS_EN
- Defined: an arriving load with FIFO empty and a free port is written directly, visible N+1, and is not enqueued. It is subject to the kill rule.
- Undefined: all loads pass through the FIFO, minimum latency 2.

Decomposition:
- Package rf_wb_pkg holds:
  - the AW function of EMBEDDED;
  - typedef wb_req_t {rd, data};
  - typedef wb_fifo_ent_t {wb_req_t req, logic kill}.
- Sub-module wb_load_fifo: parameterised depth, per-entry rd-match kill input, head/pop interface.
- Top level: port allocation, output registers, scoreboard.

Test Plan:
- Reset, then alu0 {rd=3, 0xA5A5A5A5} and alu1 {rd=7, 0x1} in cycle 0 -> cycle 1: rf0 = (3, 0xA5A5A5A5), rf1 = (7, 0x1).
- alu0 and alu1 both rd=5, data 0x11 / 0x22 -> only rf1 = (5, 0x22); rf0_rd_addr = 0.
- Both lanes busy for 4 cycles; three loads to rd 1, 2, 4 with LD_DEPTH=2:
  - ld_ready falls after 2 accepts;
  - when lanes idle, rd 1 is written on port0 first, then rd 2.
- iss_ld_rd=9, load to 9 enqueued, then alu0 writes 9 = 0xBEEF:
  - the FIFO entry is killed;
  - busy[9] clears;
  - register 9 is never written with the load data after 0xBEEF.
- Load to rd 0 and an ALU write to rd 0 -> no port write; busy stays 0.
- rst_n asserted with 2 queued loads -> outputs 0 immediately; no write of the queued data after release.
